// File: rtl/color_classifier.sv
// Periodic RGB color classifier: samples normalized channel values on a tick,
// picks the dominant channel, and commits a color after a run of agreeing passes.
module color_classifier #(
  parameter int unsigned SAMPLE_PERIOD = 50000000,
  parameter int unsigned STABLE_COUNT  = 3,
  parameter int unsigned MIN_LEVEL     = 20,
  parameter int unsigned MARGIN        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] red_norm,
  input  logic [15:0] green_norm,
  input  logic [15:0] blue_norm,
  output logic [1:0]  color,
  output logic        color_valid,
  output logic        color_change,
  output logic        busy
);

  localparam int unsigned CW          = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SAMPLE_PERIOD - 1);
  localparam logic [16:0]   MIN_LVL   = 17'(MIN_LEVEL);
  localparam logic [16:0]   MARGIN_W  = 17'(MARGIN);
  localparam logic [3:0]    STABLE    = 4'(STABLE_COUNT);

  typedef enum logic [1:0] {IDLE, CAPTURE, CLASSIFY, FILTER} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          capture, classify, filter;
  logic [15:0]   red_q, green_q, blue_q;
  logic [1:0]    cls, cls_c, win;
  logic [1:0]    cand, cand_next;
  logic [3:0]    run, run_next;
  logic          commit;
  logic [16:0]   r17, g17, b17, max_v, second_v, lead;

  // Sample tick generator; held at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    classify   = 1'b0;
    filter     = 1'b0;
    case (state)
      IDLE:     if (tick) state_next = CAPTURE;
      CAPTURE:  begin capture  = 1'b1; state_next = CLASSIFY; end
      CLASSIFY: begin classify = 1'b1; state_next = FILTER;   end
      FILTER:   begin filter   = 1'b1; state_next = IDLE;     end
      default:  state_next = IDLE;
    endcase
  end

  // Winner and runner-up; ties resolve red, then green, then blue
  always_comb begin
    r17 = {1'b0, red_q};
    g17 = {1'b0, green_q};
    b17 = {1'b0, blue_q};
    if (r17 >= g17 && r17 >= b17) begin
      win      = 2'd1;
      max_v    = r17;
      second_v = (g17 >= b17) ? g17 : b17;
    end else if (g17 >= b17) begin
      win      = 2'd2;
      max_v    = g17;
      second_v = (r17 >= b17) ? r17 : b17;
    end else begin
      win      = 2'd3;
      max_v    = b17;
      second_v = (r17 >= g17) ? r17 : g17;
    end
    lead  = max_v - second_v;
    cls_c = (max_v < MIN_LVL || lead < MARGIN_W) ? 2'd0 : win;
  end

  // Run-length filter over successive classifications
  always_comb begin
    if (cls == cand) begin
      cand_next = cand;
      run_next  = (run == 4'hF) ? run : run + 4'd1;
    end else begin
      cand_next = cls;
      run_next  = 4'd1;
    end
    commit = run_next >= STABLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      cls          <= 2'd0;
      cand         <= 2'd0;
      run          <= 4'd0;
      color        <= 2'd0;
      color_valid  <= 1'b0;
      color_change <= 1'b0;
      busy         <= 1'b0;
    end else begin
      color_change <= 1'b0;
      busy         <= (state_next != IDLE);
      if (capture) begin
        red_q   <= red_norm;
        green_q <= green_norm;
        blue_q  <= blue_norm;
      end
      if (classify) cls <= cls_c;
      if (filter) begin
        cand <= cand_next;
        run  <= run_next;
        if (commit) begin
          color        <= cand_next;
          color_valid  <= 1'b1;
          color_change <= (cand_next != color) || !color_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_color_classifier.sv
// Directed bench for color_classifier with an 8-cycle sample period.
module tb_color_classifier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] red_norm   = '0;
  logic [15:0] green_norm = '0;
  logic [15:0] blue_norm  = '0;
  logic [1:0]  color;
  logic        color_valid;
  logic        color_change;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  color_classifier #(
    .SAMPLE_PERIOD(8),
    .STABLE_COUNT (3),
    .MIN_LEVEL    (20),
    .MARGIN       (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .red_norm    (red_norm),
    .green_norm  (green_norm),
    .blue_norm   (blue_norm),
    .color       (color),
    .color_valid (color_valid),
    .color_change(color_change),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse tally, sampled at the rising edge ending each pulse cycle
  always @(posedge clk) if (color_change === 1'b1) pulses <= pulses + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_rgb(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    red_norm   = r;
    green_norm = g;
    blue_norm  = b;
  endtask

  // Wait for a pass to start, optionally change inputs during CLASSIFY, stop just after FILTER
  task automatic run_pass(input bit sw, input logic [15:0] r2, input logic [15:0] g2,
                          input logic [15:0] b2);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 20);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pass_start busy=%b required 1 within 20 cycles", busy);
    end
    @(negedge clk);
    if (sw) set_rgb(r2, g2, b2);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pass();
    run_pass(1'b0, 16'd0, 16'd0, 16'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (color !== 2'd0 || color_valid !== 1'b0 || color_change !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got color=%0d valid=%b change=%b busy=%b required 0 0 0 0",
               color, color_valid, color_change, busy);
    end
    rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (busy === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL en_low_idle busy=1 required 0 while en=0");
      end
    end
  endtask

  task automatic test_red();
    int p0;
    set_rgb(16'd80, 16'd30, 16'd25);
    en = 1'b1;
    p0 = pulses;
    pass();
    checks++;
    if (color_valid !== 1'b0) begin
      errors++;
      $display("FAIL red_pass1 valid=%b required 0", color_valid);
    end
    pass();
    checks++;
    if (color_valid !== 1'b0) begin
      errors++;
      $display("FAIL red_pass2 valid=%b required 0", color_valid);
    end
    pass();
    checks++;
    if (color !== 2'd1 || color_valid !== 1'b1 || color_change !== 1'b1) begin
      errors++;
      $display("FAIL red_commit got color=%0d valid=%b change=%b required 1 1 1",
               color, color_valid, color_change);
    end
    @(negedge clk);
    checks++;
    if (color_change !== 1'b0) begin
      errors++;
      $display("FAIL red_pulse_width change=%b required 0", color_change);
    end
    pass();
    pass();
    checks++;
    if (color !== 2'd1 || pulses - p0 != 1) begin
      errors++;
      $display("FAIL red_hold got color=%0d pulses=%0d required 1 and 1", color, pulses - p0);
    end
  endtask

  task automatic test_green_switch();
    int p0;
    set_rgb(16'd10, 16'd100, 16'd10);
    p0 = pulses;
    for (int i = 0; i < 2; i++) begin
      pass();
      checks++;
      if (color !== 2'd1 || color_change !== 1'b0) begin
        errors++;
        $display("FAIL green_pre%0d got color=%0d change=%b required 1 0", i, color, color_change);
      end
    end
    // Inputs revert to red during CLASSIFY; captured green must still win
    run_pass(1'b1, 16'd80, 16'd30, 16'd25);
    checks++;
    if (color !== 2'd2 || color_change !== 1'b1) begin
      errors++;
      $display("FAIL green_capture got color=%0d change=%b required 2 1", color, color_change);
    end
    pass();
    checks++;
    if (color !== 2'd2 || color_change !== 1'b0 || pulses - p0 != 1) begin
      errors++;
      $display("FAIL green_hold got color=%0d change=%b pulses=%0d required 2 0 1",
               color, color_change, pulses - p0);
    end
  endtask

  task automatic test_reset_filter();
    int n;
    set_rgb(16'd50, 16'd45, 16'd10);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 20);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (color !== 2'd0 || color_valid !== 1'b0 || color_change !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_filter got color=%0d valid=%b change=%b busy=%b required 0 0 0 0",
               color, color_valid, color_change, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b1 && n < 20);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL first_tick_after_reset took %0d cycles required 8", n);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (color !== 2'd0 || color_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_pass got color=%0d valid=%b required 0 0", color, color_valid);
    end
  endtask

  // Continues from the first post-reset pass, which already classified NONE
  task automatic test_low_margin();
    int p0;
    p0 = pulses;
    pass();
    checks++;
    if (color_valid !== 1'b0) begin
      errors++;
      $display("FAIL margin_pass2 valid=%b required 0", color_valid);
    end
    pass();
    checks++;
    if (color !== 2'd0 || color_valid !== 1'b1 || color_change !== 1'b1) begin
      errors++;
      $display("FAIL margin_commit got color=%0d valid=%b change=%b required 0 1 1",
               color, color_valid, color_change);
    end
    @(negedge clk);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL margin_pulses got %0d required 1", pulses - p0);
    end
  endtask

  task automatic test_dim();
    int p0;
    p0 = pulses;
    set_rgb(16'd15, 16'd15, 16'd15);
    pass();
    set_rgb(16'd5, 16'd5, 16'd90);
    pass();
    pass();
    checks++;
    if (color !== 2'd0) begin
      errors++;
      $display("FAIL dim_blue_blip got color=%0d required 0", color);
    end
    set_rgb(16'd15, 16'd15, 16'd15);
    for (int i = 0; i < 3; i++) pass();
    checks++;
    if (color !== 2'd0 || color_valid !== 1'b1 || color_change !== 1'b0) begin
      errors++;
      $display("FAIL dim_recommit got color=%0d valid=%b change=%b required 0 1 0",
               color, color_valid, color_change);
    end
    @(negedge clk);
    checks++;
    if (pulses - p0 != 0) begin
      errors++;
      $display("FAIL dim_pulses got %0d required 0", pulses - p0);
    end
  endtask

  task automatic test_boundary();
    // Exactly MIN_LEVEL with exactly MARGIN lead is a valid green
    set_rgb(16'd10, 16'd20, 16'd10);
    pass();
    pass();
    checks++;
    if (color !== 2'd0) begin
      errors++;
      $display("FAIL edge_green_early got color=%0d required 0", color);
    end
    pass();
    checks++;
    if (color !== 2'd2 || color_change !== 1'b1) begin
      errors++;
      $display("FAIL edge_green got color=%0d change=%b required 2 1", color, color_change);
    end
    // Full-scale values must not wrap
    set_rgb(16'd65525, 16'd0, 16'd65535);
    pass();
    pass();
    checks++;
    if (color !== 2'd2) begin
      errors++;
      $display("FAIL full_scale_early got color=%0d required 2", color);
    end
    pass();
    checks++;
    if (color !== 2'd3 || color_change !== 1'b1) begin
      errors++;
      $display("FAIL full_scale_blue got color=%0d change=%b required 3 1", color, color_change);
    end
    // A red/green tie has zero lead and is NONE
    set_rgb(16'd100, 16'd100, 16'd0);
    for (int i = 0; i < 3; i++) pass();
    checks++;
    if (color !== 2'd0 || color_change !== 1'b1) begin
      errors++;
      $display("FAIL tie_none got color=%0d change=%b required 0 1", color, color_change);
    end
  endtask

  initial begin
    test_reset();
    test_red();
    test_green_switch();
    test_reset_filter();
    test_low_margin();
    test_dim();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_classifier.md
COLOR_CLASSIFIER -- requirements
Module: color_classifier

Interface
REQ-001 The block SHALL have parameter SAMPLE_PERIOD, default 50000000, meaning clock cycles between samples (legal range >= 4).
REQ-002 The block SHALL have parameter STABLE_COUNT, default 3, meaning consecutive identical classifications needed to commit a color (legal range 1..15).
REQ-003 The block SHALL have parameter MIN_LEVEL, default 20, meaning the minimum winning channel value for a valid color.
REQ-004 The block SHALL have parameter MARGIN, default 10, meaning the minimum lead of the winner over the runner-up.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port en, input, 1 bit: sampling enable.
REQ-008 The block SHALL have ports red_norm, green_norm and blue_norm, input, 16 bits each: normalized channel values from the color sensor stage.
REQ-009 The block SHALL have port color, output, 2 bits: committed color, 0=NONE, 1=RED, 2=GREEN, 3=BLUE.
REQ-010 The block SHALL have port color_valid, output, 1 bit: high once any color (including NONE) has been committed.
REQ-011 The block SHALL have port color_change, output, 1 bit: one-cycle pulse on each commit that changes color.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the FSM is outside IDLE.

Function
REQ-013 The tick counter SHALL count 0..SAMPLE_PERIOD-1 while en=1, wrap to 0, and assert an internal tick on the cycle where the count equals SAMPLE_PERIOD-1.
REQ-014 While en=0, the tick counter SHALL hold at 0; an FSM pass already in progress SHALL complete.
REQ-015 The FSM SHALL have states IDLE, CAPTURE, CLASSIFY and FILTER, with transitions IDLE->CAPTURE on tick, CAPTURE->CLASSIFY, CLASSIFY->FILTER and FILTER->IDLE, each unconditional after one cycle.
REQ-016 In CAPTURE, the block SHALL latch all three inputs into internal registers; later input changes SHALL NOT affect the current pass.
REQ-017 In CLASSIFY, the block SHALL identify the maximum channel and the second-largest channel using 17-bit unsigned arithmetic, with no overflow or wrap.
REQ-018 The classification SHALL be NONE if max < MIN_LEVEL or (max - second) < MARGIN; otherwise it SHALL be the channel holding the maximum.
REQ-019 Exact ties with MARGIN=0 SHALL resolve with priority RED > GREEN > BLUE.
REQ-020 In FILTER, if the classification equals the candidate, the block SHALL increment a 4-bit run counter, saturating at 15; otherwise it SHALL set candidate := classification and run := 1.
REQ-021 In FILTER, when the updated run is >= STABLE_COUNT, the block SHALL set color := candidate and color_valid := 1; color_change SHALL pulse for exactly the next cycle only if the new color differs from the previous color or color_valid was 0.
REQ-022 The outputs SHALL update at the clock edge ending FILTER, i.e. 3 cycles after the tick cycle; color SHALL hold between commits.
REQ-023 With STABLE_COUNT=1, every pass SHALL commit immediately.
REQ-024 The tick SHALL NOT be lost or queued, because SAMPLE_PERIOD >= 4 guarantees the FSM is in IDLE at each tick.

Reset
REQ-025 Asserting rst at any time, including mid-pass, SHALL immediately force state=IDLE, tick counter=0, latched inputs=0, candidate=NONE, run=0, color=0, color_valid=0, color_change=0 and busy=0.
REQ-026 After rst is released, the first tick SHALL occur SAMPLE_PERIOD cycles later.

Verification (SAMPLE_PERIOD=8, STABLE_COUNT=3, MIN_LEVEL=20, MARGIN=10)
REQ-027 The bench SHALL cover: R=80, G=30, B=25 held, en=1 -> color=1, color_valid=1 after the 3rd tick plus 3 cycles, color_change one pulse, no further pulses.
REQ-028 The bench SHALL cover: R=50, G=45, B=10 -> classification NONE; after 3 passes color=0, color_valid=1, color_change pulse once.
REQ-029 The bench SHALL cover: R=G=B=15 -> NONE (below MIN_LEVEL); then switching to B=90, R=G=5 for 2 passes and back -> color remains 0 with no pulse.
REQ-030 The bench SHALL cover: committed RED, then inputs G=100, R=B=10 -> color becomes 2 on the 3rd GREEN pass with a single color_change pulse.
REQ-031 The bench SHALL cover: inputs changed during the CLASSIFY cycle -> the current pass uses the values captured in CAPTURE.
REQ-032 The bench SHALL cover: rst asserted during FILTER -> all outputs 0 in the same cycle; the next tick arrives 8 cycles after release.
